alu_op_sequencer: RTL and testbench

Multi-cycle controller that sequences the 32-bit ALU and its Y/Z/HI/LO register strobes for one instruction at a time. It accepts a 5-bit opcode through a valid/ready handshake and decodes it to the ALU's one-hot control vector. It then drives bus-out/register-in strobes through operand load, execute and writeback, and pulses done. It sits between the control unit and the datapath, and it gives MUL/DIV a configurable multicycle execute window.

---
 rtl/alu_seq_pkg.sv | 51 +++++
 rtl/alu_op_decode.sv | 43 ++++
 rtl/alu_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, ALU select indices, FSM encoding and decode record for alu_op_sequencer
package alu_seq_pkg;

    localparam int CNT_W = 6;
    localparam int ALU_W = 14;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_MUL   = 2;
    localparam int ALU_DIV   = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_OR    = 5;
    localparam int ALU_SHR   = 6;
    localparam int ALU_SHRA  = 7;
    localparam int ALU_SHL   = 8;
    localparam int ALU_ROR   = 9;
    localparam int ALU_ROL   = 10;
    localparam int ALU_NEG   = 11;
    localparam int ALU_NOT   = 12;
    localparam int ALU_INCPC = 13;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_Y = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB_LO  = 3'd3;
    localparam logic [2:0] S_WB_HI  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    typedef struct packed {
        logic [ALU_W-1:0] onehot;
        logic             legal;
        logic             is_unary;
        logic             is_muldiv;
    } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode to one-hot ALU select and class flags
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [4:0] opcode,
    output dec_t       dec
);

    // IncPC is never selected here; PC increment belongs to fetch.
    always_comb begin
        dec = '0;
        dec.legal = 1'b1;
        case (opcode)
            OP_ADD:  dec.onehot[ALU_ADD]  = 1'b1;
            OP_SUB:  dec.onehot[ALU_SUB]  = 1'b1;
            OP_SHR:  dec.onehot[ALU_SHR]  = 1'b1;
            OP_SHRA: dec.onehot[ALU_SHRA] = 1'b1;
            OP_SHL:  dec.onehot[ALU_SHL]  = 1'b1;
            OP_ROR:  dec.onehot[ALU_ROR]  = 1'b1;
            OP_ROL:  dec.onehot[ALU_ROL]  = 1'b1;
            OP_AND:  dec.onehot[ALU_AND]  = 1'b1;
            OP_OR:   dec.onehot[ALU_OR]   = 1'b1;
            OP_MUL: begin
                dec.onehot[ALU_MUL] = 1'b1;
                dec.is_muldiv       = 1'b1;
            end
            OP_DIV: begin
                dec.onehot[ALU_DIV] = 1'b1;
                dec.is_muldiv       = 1'b1;
            end
            OP_NEG: begin
                dec.onehot[ALU_NEG] = 1'b1;
                dec.is_unary        = 1'b1;
            end
            OP_NOT: begin
                dec.onehot[ALU_NOT] = 1'b1;
                dec.is_unary        = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU/register strobe sequencer; ALUSEQ_PERF_EN adds busy/op counters
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clock,
    input  logic             clear_n,
`ifdef ALUSEQ_PERF_EN
    output logic [31:0]      busy_cycles,
    output logic [15:0]      op_count,
`endif
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [4:0]       opcode,
    output logic             src1_out,
    output logic             y_in,
    output logic             src2_out,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             z_in,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             dst_in,
    output logic             lo_in,
    output logic             hi_in,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] ALU_M1 = CNT_W'(ALU_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic [4:0]       dec_op;
    logic [CNT_W-1:0] lat_m1;
    dec_t             dec;

    // In IDLE the live opcode steers the accept decision; afterwards the latched one.
    assign dec_op = (state_q == S_IDLE) ? opcode : op_q;

    alu_op_decode u_decode (
        .opcode (dec_op),
        .dec    (dec)
    );

    always_comb begin
        lat_m1 = ALU_M1;
        if (dec.is_muldiv) begin
            lat_m1 = dec.onehot[ALU_MUL] ? MUL_M1 : DIV_M1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d = opcode;
                    if (!dec.legal) begin
                        state_d = S_ERR;
                    end else if (dec.is_unary) begin
                        state_d = S_EXEC;
                        cnt_d   = lat_m1;
                    end else begin
                        state_d = S_LOAD_Y;
                    end
                end
            end
            S_LOAD_Y: begin
                state_d = S_EXEC;
                cnt_d   = lat_m1;
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_WB_LO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WB_LO: state_d = dec.is_muldiv ? S_WB_HI : S_DONE;
            S_WB_HI: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Strobes are pure functions of the registered state so a reset edge kills them at once.
    always_comb begin
        op_ready = (state_q == S_IDLE);
        src1_out = 1'b0;
        y_in     = 1'b0;
        src2_out = 1'b0;
        alu_ctrl = '0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        zhi_out  = 1'b0;
        dst_in   = 1'b0;
        lo_in    = 1'b0;
        hi_in    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_LOAD_Y: begin
                src1_out = 1'b1;
                y_in     = 1'b1;
            end
            S_EXEC: begin
                src2_out = 1'b1;
                alu_ctrl = dec.onehot;
                z_in     = (cnt_q == '0);
            end
            S_WB_LO: begin
                zlo_out = 1'b1;
                lo_in   = dec.is_muldiv;
                dst_in  = !dec.is_muldiv;
            end
            S_WB_HI: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ALUSEQ_PERF_EN
    logic [31:0] busy_q, busy_d;
    logic [15:0] opcnt_q, opcnt_d;

    always_comb begin
        busy_d  = busy_q;
        opcnt_d = opcnt_q;
        if (state_q != S_IDLE && busy_q != '1) begin
            busy_d = busy_q + 1'b1;
        end
        if (state_q == S_DONE && opcnt_q != '1) begin
            opcnt_d = opcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            busy_q  <= '0;
            opcnt_q <= '0;
        end else begin
            busy_q  <= busy_d;
            opcnt_q <= opcnt_d;
        end
    end

    assign busy_cycles = busy_q;
    assign op_count    = opcnt_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer against a cycle-trace reference model
module tb_alu_op_sequencer;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;
    localparam int ALU_LAT = 1;

    localparam int B_ERR  = 0;
    localparam int B_DONE = 1;
    localparam int B_HI   = 2;
    localparam int B_LO   = 3;
    localparam int B_DST  = 4;
    localparam int B_ZHI  = 5;
    localparam int B_ZLO  = 6;
    localparam int B_ZIN  = 7;
    localparam int B_ALU  = 8;
    localparam int B_SRC2 = 22;
    localparam int B_YIN  = 23;
    localparam int B_SRC1 = 24;
    localparam int B_RDY  = 25;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [4:0]  opcode = 5'd0;
    logic        src1_out, y_in, src2_out, z_in, zlo_out, zhi_out;
    logic        dst_in, lo_in, hi_in, done, err;
    logic [13:0] alu_ctrl;
`ifdef ALUSEQ_PERF_EN
    logic [31:0] busy_cycles;
    logic [15:0] op_count;
`endif

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;
    logic [25:0] exp_q[$];

    always #5 clock = ~clock;

    alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ALU_LAT(ALU_LAT)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
`ifdef ALUSEQ_PERF_EN
        .busy_cycles (busy_cycles),
        .op_count    (op_count),
`endif
        .op_valid (op_valid),
        .op_ready (op_ready),
        .opcode   (opcode),
        .src1_out (src1_out),
        .y_in     (y_in),
        .src2_out (src2_out),
        .alu_ctrl (alu_ctrl),
        .z_in     (z_in),
        .zlo_out  (zlo_out),
        .zhi_out  (zhi_out),
        .dst_in   (dst_in),
        .lo_in    (lo_in),
        .hi_in    (hi_in),
        .done     (done),
        .err      (err)
    );

    // ALU select index for each legal opcode, -1 for illegal.
    function automatic int ref_index(input logic [4:0] op);
        case (op)
            5'b00011: return 0;
            5'b00100: return 1;
            5'b01111: return 2;
            5'b10000: return 3;
            5'b01010: return 4;
            5'b01011: return 5;
            5'b00101: return 6;
            5'b00110: return 7;
            5'b00111: return 8;
            5'b01000: return 9;
            5'b01001: return 10;
            5'b10001: return 11;
            5'b10010: return 12;
            default:  return -1;
        endcase
    endfunction

    task automatic push_trace(input logic [4:0] op);
        int idx, lat;
        bit md, un;
        logic [25:0] v;
        idx = ref_index(op);
        if (idx < 0) begin
            v = '0; v[B_ERR] = 1'b1; v[B_DONE] = 1'b1;
            exp_q.push_back(v);
            return;
        end
        md  = (idx == 2) || (idx == 3);
        un  = (idx == 11) || (idx == 12);
        lat = (idx == 2) ? MUL_LAT : (idx == 3) ? DIV_LAT : ALU_LAT;
        if (!un) begin
            v = '0; v[B_SRC1] = 1'b1; v[B_YIN] = 1'b1;
            exp_q.push_back(v);
        end
        for (int k = 0; k < lat; k++) begin
            v = '0; v[B_SRC2] = 1'b1; v[B_ALU + idx] = 1'b1;
            if (k == lat - 1) v[B_ZIN] = 1'b1;
            exp_q.push_back(v);
        end
        v = '0; v[B_ZLO] = 1'b1;
        if (md) v[B_LO] = 1'b1; else v[B_DST] = 1'b1;
        exp_q.push_back(v);
        if (md) begin
            v = '0; v[B_ZHI] = 1'b1; v[B_HI] = 1'b1;
            exp_q.push_back(v);
        end
        v = '0; v[B_DONE] = 1'b1;
        exp_q.push_back(v);
    endtask

    // Monitor: compare the current cycle, then enqueue the trace of an accept seen this cycle.
    always @(negedge clock) begin
        logic [25:0] obs, exp_v;
        obs = {op_ready, src1_out, y_in, src2_out, alu_ctrl, z_in, zlo_out, zhi_out,
               dst_in, lo_in, hi_in, done, err};
        if (armed) begin
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
            end else begin
                exp_v = '0;
                exp_v[B_RDY] = 1'b1;
            end
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, obs, exp_v);
            end
        end
        if (!clear_n) begin
            exp_q.delete();
            armed = 1'b1;
        end else if (armed && op_valid && op_ready) begin
            push_trace(opcode);
        end
    end

    task automatic issue(input logic [4:0] op);
        bit got;
        got = 1'b0;
        op_valid = 1'b1;
        opcode   = op;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (op_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout op=%b actual=no_accept required=accept", op);
        end
        @(posedge clock); #1;
        op_valid = 1'b0;
        opcode   = 5'($urandom);
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (op_ready && exp_q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fails++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    logic [4:0] legal_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                   5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                   5'b10000, 5'b10001, 5'b10010};

    initial begin
        repeat (2) @(posedge clock);
        #1 clear_n = 1'b1;
        @(posedge clock); #1;

        issue(5'b00011); wait_idle();
        issue(5'b10010); wait_idle();
        issue(5'b01111); wait_idle();
        issue(5'b10000); wait_idle();
        issue(5'b00000); wait_idle();
        issue(5'b00011); wait_idle();
        issue(5'b11111); wait_idle();
        issue(5'b10001); wait_idle();

        // Reset during the first MUL EXEC cycle: no writeback may follow.
        issue(5'b01111);
        @(posedge clock); #1;
        clear_n = 1'b0;
        @(posedge clock); #1;
        clear_n = 1'b1;
        wait_idle();

        for (int c = 0; c < 600; c++) begin
            op_valid = 1'($urandom);
            if ($urandom_range(3, 0) != 0) opcode = legal_ops[$urandom_range(12, 0)];
            else opcode = 5'($urandom);
            clear_n = ($urandom_range(59, 0) != 0);
            @(posedge clock); #1;
        end
        clear_n  = 1'b1;
        op_valid = 1'b0;
        wait_idle();
        @(posedge clock); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
